// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - issue/readback bundle between the EX stage and the multiply/divide unit
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             req;
  logic [1:0]       read_sel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (
    output start, op, src_a, src_b, req, read_sel,
    input  busy, done, result
  );

  modport slave (
    input  start, op, src_a, src_b, req, read_sel,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit holding architectural HI/LO
module mdu_iter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);

  localparam int W2 = 2 * WIDTH;
  localparam int IW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [2:0] {IDLE, MUL, DIV_PRE, DIV_ITER, DIV_POST} state_t;

  state_t           state;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [3:0]       cnt;
  logic [IW-1:0]    iter;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             q_neg, r_neg, div_zero, done_q;

  function automatic logic is_mul(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) ||
           (o == OP_MADDU) || (o == OP_MSUB) || (o == OP_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] o);
    return (o == OP_MULT) || (o == OP_DIV) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [W2-1:0]    ext_a, ext_b, prod, acc, mul_res;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] q_fin, r_fin;

  // Datapath for the latched op: product/accumulate, operand magnitudes, one divide step, final signs
  always_comb begin
    sgn     = is_signed_op(op_q);
    a_neg   = sgn & a_q[WIDTH-1];
    b_neg   = sgn & b_q[WIDTH-1];
    abs_a   = a_neg ? -a_q : a_q;
    abs_b   = b_neg ? -b_q : b_q;
    ext_a   = sgn ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    ext_b   = sgn ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    prod    = ext_a * ext_b;
    acc     = {hi, lo};
    mul_res = prod;
    if ((op_q == OP_MADD) || (op_q == OP_MADDU)) begin
      mul_res = acc + prod;
    end else if ((op_q == OP_MSUB) || (op_q == OP_MSUBU)) begin
      mul_res = acc - prod;
    end
    // Partial remainder stays below the divisor, so the W-bit difference is exact when it is taken
    rem_sh  = {rem, quo[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, dvs});
    rem_sub = rem_sh[WIDTH-1:0] - dvs;
    q_fin   = q_neg ? -quo : quo;
    r_fin   = r_neg ? -rem : rem;
  end

  // Busy covers the issue cycle of a multi-cycle op so the pipeline stalls immediately
  always_comb begin
    bus.busy = (state != IDLE) |
               (bus.start & (is_mul(bus.op) | is_div(bus.op)) & ~bus.req);
    bus.done = done_q;
    case (bus.read_sel)
      2'b01:   bus.result = lo;
      2'b10:   bus.result = hi;
      default: bus.result = '0;
    endcase
  end

  // Control FSM plus HI/LO and all iteration state; HI/LO only change at mt*, MUL end and DIV_POST
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      iter     <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.req) begin
            if (is_mul(bus.op)) begin
              a_q   <= bus.src_a;
              b_q   <= bus.src_b;
              op_q  <= bus.op;
              cnt   <= 4'(MUL_CYCLES - 1);
              state <= MUL;
            end else if (is_div(bus.op)) begin
              a_q   <= bus.src_a;
              b_q   <= bus.src_b;
              op_q  <= bus.op;
              state <= DIV_PRE;
            end else if (bus.op == OP_MTHI) begin
              hi <= bus.src_a;
            end else if (bus.op == OP_MTLO) begin
              lo <= bus.src_a;
            end
          end
        end
        MUL: begin
          if (cnt == 4'd0) begin
            {hi, lo} <= mul_res;
            done_q   <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DIV_PRE: begin
          quo      <= abs_a;
          dvs      <= abs_b;
          rem      <= '0;
          q_neg    <= a_neg ^ b_neg;
          r_neg    <= a_neg;
          div_zero <= (b_q == '0);
          iter     <= '0;
          state    <= DIV_ITER;
        end
        DIV_ITER: begin
          if (rem_ge) begin
            rem <= rem_sub;
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          if (iter == IW'(WIDTH - 1)) begin
            state <= DIV_POST;
          end else begin
            iter <= iter + IW'(1);
          end
        end
        DIV_POST: begin
          // Divide-by-zero has a fixed architectural result independent of signedness
          if (div_zero) begin
            lo <= '1;
            hi <= a_q;
          end else begin
            lo <= q_fin;
            hi <= r_fin;
          end
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
